// File: rtl/rom_arb.sv
`default_nettype none
// rom_arb: round-robin arbiter sharing a 1-cycle-latency ROM among N requesters,
// with a single response slot that captures ROM data when the consumer stalls.
module rom_arb #(
  parameter int N = 4,
  parameter int A = 6,
  parameter int D = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*A-1:0] req_addr,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [IW-1:0]  resp_id,
  output logic [D-1:0]   resp_data,
  output logic           rom_en,
  output logic [A-1:0]   rom_addr,
  input  logic [D-1:0]   rom_data
);

  logic          busy;
  logic          held;
  logic [IW-1:0] id_q;
  logic [D-1:0]  hold_q;
  logic [IW-1:0] ptr;

  logic          slot_free;
  logic          issue;
  logic          found;
  logic [IW-1:0] grant;
  logic [IW:0]   idx;
  logic [IW:0]   ptr_nxt;

  assign slot_free = ~busy | resp_ready;
  assign issue     = slot_free & (|req_valid) & ~rst;

  // Search starts at ptr and wraps modulo N; one extra bit keeps the sum from overflowing.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        grant = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_nxt = {1'b0, grant} + (IW+1)'(1);
    if (ptr_nxt >= (IW+1)'(N)) ptr_nxt = '0;
  end

  always_comb begin
    req_ready = '0;
    rom_addr  = '0;
    for (int i = 0; i < N; i++) begin
      if (issue && grant == IW'(i)) begin
        req_ready[i] = 1'b1;
        rom_addr     = req_addr[i*A +: A];
      end
    end
  end

  assign rom_en = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      held   <= 1'b0;
      id_q   <= '0;
      hold_q <= '0;
      ptr    <= '0;
    end else if (issue) begin
      busy <= 1'b1;
      held <= 1'b0;
      id_q <= grant;
      ptr  <= ptr_nxt[IW-1:0];
    end else if (busy && resp_ready) begin
      busy <= 1'b0;
      held <= 1'b0;
    end else if (busy && !held) begin
      // ROM data is only valid for one cycle; keep it while the consumer stalls.
      held   <= 1'b1;
      hold_q <= rom_data;
    end
  end

  assign resp_valid = busy;
  assign resp_id    = id_q;
  assign resp_data  = held ? hold_q : rom_data;

endmodule
`default_nettype wire

// File: tb/tb_rom_arb.sv
`default_nettype none
// Scoreboard bench for rom_arb: directed vectors push expected responses, a monitor pops them.
module tb_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [31:0] resp_data;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] d039 [5] = '{32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D, 32'h0A0A0A0A};

  always #5 clk = ~clk;

  rom_arb #(.N(4), .A(6), .D(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data)
  );

  // ROM: mem[k] = k * 0x01010101, returns junk when not enabled so stale reads show up.
  always @(posedge clk)
    rom_data <= rom_en ? {4{2'b00, rom_addr}} : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [5:0] a);
    req_addr[i*6 +: 6] = a;
  endtask

  task automatic expect_issue(input string name, input logic [3:0] rdy, input logic [5:0] addr,
                              input logic [1:0] id, input logic [31:0] data);
    sample;
    chk({name, "_req_ready"}, req_ready, rdy);
    chk({name, "_rom_en"}, rom_en, 1);
    chk({name, "_rom_addr"}, rom_addr, addr);
    sb.push_back(exp_t'({id, data}));
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_resp actual id=%0d data=%0h required=no response", resp_id, resp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_id", resp_id, mon_e.id);
        chk("resp_data", resp_data, mon_e.data);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    req_addr   = '0;
    #1;
    repeat (2) begin
      sample;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rom_en", rom_en, 0);
    end
    next_cycle;
    rst       = 1'b0;
    req_valid = 4'h0;
    sample;
    chk("post_rst_valid", resp_valid, 0);
    chk("post_rst_id", resp_id, 0);

    // All requesters valid: grants rotate 0,1,2,3,0.
    next_cycle;
    for (int i = 0; i < 4; i++) set_addr(i, 6'(10 + i));
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      expect_issue("rr", 4'(1 << (i % 4)), 6'(10 + i % 4), 2'(i % 4), d039[i]);
      next_cycle;
    end

    // Single requester 2, addr 5 (ptr is 1 here).
    req_valid = 4'b0100;
    set_addr(2, 6'd5);
    expect_issue("single", 4'b0100, 6'd5, 2'd2, 32'h05050505);
    next_cycle;
    req_valid = 4'h0;
    sample;
    chk("single_resp_valid", resp_valid, 1);
    chk("single_resp_id", resp_id, 2);
    next_cycle;
    sample;
    chk("idle_resp_valid", resp_valid, 0);

    // Requester 1 reads addr 7 under a 3-cycle stall.
    next_cycle;
    req_valid  = 4'b0010;
    resp_ready = 1'b0;
    set_addr(1, 6'd7);
    expect_issue("stall", 4'b0010, 6'd7, 2'd1, 32'h07070707);
    next_cycle;
    set_addr(1, 6'd8);
    for (int s = 0; s < 3; s++) begin
      sample;
      chk("stall_valid", resp_valid, 1);
      chk("stall_id", resp_id, 1);
      chk("stall_data", resp_data, 32'h07070707);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_rom_en", rom_en, 0);
      next_cycle;
    end
    resp_ready = 1'b1;
    expect_issue("stall_release", 4'b0010, 6'd8, 2'd1, 32'h08080808);
    next_cycle;

    // ptr = 2 with requesters 3 and 0 valid: grant 3, then 0.
    req_valid = 4'b1001;
    set_addr(3, 6'd20);
    set_addr(0, 6'd21);
    expect_issue("wrap_g3", 4'b1000, 6'd20, 2'd3, 32'h14141414);
    next_cycle;
    expect_issue("wrap_g0", 4'b0001, 6'd21, 2'd0, 32'h15151515);
    next_cycle;
    req_valid = 4'h0;
    sample;

    // Reset while a stalled response is pending: it must never be delivered.
    next_cycle;
    req_valid  = 4'b0001;
    resp_ready = 1'b0;
    set_addr(0, 6'd30);
    sample;
    chk("pre_rst_req_ready", req_ready, 4'b0001);
    next_cycle;
    req_valid = 4'h0;
    rst       = 1'b1;
    sample;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rom_en", rom_en, 0);
    next_cycle;
    rst = 1'b0;
    sample;
    chk("after_rst_valid", resp_valid, 0);
    next_cycle;
    resp_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sample;
      chk("no_stale_valid", resp_valid, 0);
      next_cycle;
    end

    // ptr was cleared by reset: requester 2 alone is granted normally.
    req_valid = 4'b0100;
    set_addr(2, 6'd3);
    expect_issue("post_rst_issue", 4'b0100, 6'd3, 2'd2, 32'h03030303);
    next_cycle;
    req_valid = 4'h0;
    sample;
    next_cycle;
    sample;
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
